led_column_scanner: RTL and testbench

Sequential front end for the Conway LED array driver. It time-multiplexes the N×N display one column at a time and produces the column-enable, column-index and frame-image signals that the combinational row/column driver consumes. It also double-buffers generations arriving from the Conway engine through a valid/ready handshake. The displayed image changes only at frame boundaries, never while a column is lit.

---
 rtl/led_column_scanner.sv | 179 +++++++++++++++++
 tb/tb_led_column_scanner.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/led_column_scanner.sv
// Column-multiplexing front end for the Conway LED array: BLANK/DRIVE column timing plus a
// double-buffered frame register. Optional PWM dimming is enabled by LED_SCAN_BRIGHTNESS_EN.
module led_column_scanner #(
    parameter int N             = 5,
    parameter int TICKS_PER_COL = 1000,
    parameter int BLANK_TICKS   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*N-1:0]       cells_in,
    input  logic                 cells_valid,
    output logic                 cells_ready,
`ifdef LED_SCAN_BRIGHTNESS_EN
    input  logic [3:0]           brightness,
`endif
    output logic                 ena,
    output logic [$clog2(N):0]   x,
    output logic [N*N-1:0]       cells,
    output logic                 frame_start
);

    localparam int XW   = $clog2(N) + 1;
    localparam int MAXT = (TICKS_PER_COL > BLANK_TICKS) ? TICKS_PER_COL : BLANK_TICKS;
    localparam int DW   = $clog2(MAXT + 1);

    if (N < 1 || N > 8) begin : g_bad_n
        $error("led_column_scanner: N must be in 1..8");
    end
    if (TICKS_PER_COL < 1) begin : g_bad_ticks
        $error("led_column_scanner: TICKS_PER_COL must be >= 1");
    end
    if (BLANK_TICKS < 1) begin : g_bad_blank
        $error("led_column_scanner: BLANK_TICKS must be >= 1");
    end

    typedef enum logic [0:0] {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_t;

    state_t          state_r, state_s;
    logic [DW-1:0]   dwell_r, dwell_s;
    logic [XW-1:0]   x_r, x_s;
    logic            ena_r, ena_s;
    logic            frame_start_r, frame_start_s;
    logic            enter_drive_s;
    logic            leave_drive_s;
    logic            swap_s;
    logic            accept_s;
    logic [N*N-1:0]  pending_r;
    logic            pending_full_r;
    logic [N*N-1:0]  cells_r;

    function automatic logic [XW-1:0] next_col(input logic [XW-1:0] col);
        if (col == XW'(N - 1)) begin
            next_col = {XW{1'b0}};
        end else begin
            next_col = col + {{(XW-1){1'b0}}, 1'b1};
        end
    endfunction

    // Column timing: dwell counting, state transitions and column advance.
    always_comb begin
        state_s       = state_r;
        dwell_s       = dwell_r + {{(DW-1){1'b0}}, 1'b1};
        x_s           = x_r;
        enter_drive_s = 1'b0;
        leave_drive_s = 1'b0;
        case (state_r)
            BLANK: begin
                if (dwell_r == DW'(BLANK_TICKS - 1)) begin
                    state_s       = DRIVE;
                    dwell_s       = {DW{1'b0}};
                    enter_drive_s = 1'b1;
                end else begin
                    state_s = BLANK;
                end
            end
            DRIVE: begin
                if (dwell_r == DW'(TICKS_PER_COL - 1)) begin
                    state_s       = BLANK;
                    dwell_s       = {DW{1'b0}};
                    leave_drive_s = 1'b1;
                    x_s           = next_col(x_r);
                end else begin
                    state_s = DRIVE;
                end
            end
            default: begin
                state_s = BLANK;
                dwell_s = {DW{1'b0}};
                x_s     = {XW{1'b0}};
            end
        endcase
    end

    // The frame swaps only as column N-1 goes dark, so the image never changes mid-column.
    always_comb begin
        swap_s        = leave_drive_s && (x_r == XW'(N - 1));
        accept_s      = cells_valid && !pending_full_r;
        frame_start_s = (state_s == BLANK) && (x_s == {XW{1'b0}}) && (dwell_s == {DW{1'b0}});
    end

`ifdef LED_SCAN_BRIGHTNESS_EN
    logic [3:0] pwm_r, pwm_s;
    logic [3:0] bright_r, bright_s;

    // PWM phase restarts and brightness is latched on each entry to DRIVE.
    always_comb begin
        if (enter_drive_s) begin
            pwm_s    = 4'd0;
            bright_s = brightness;
        end else begin
            pwm_s    = pwm_r + 4'd1;
            bright_s = bright_r;
        end
        ena_s = (state_s == DRIVE) && (pwm_s < bright_s);
    end

    // PWM counter and latched brightness registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_r    <= 4'd0;
            bright_r <= 4'd0;
        end else begin
            pwm_r    <= pwm_s;
            bright_r <= bright_s;
        end
    end
`else
    // Without dimming the column is lit for the whole DRIVE phase.
    always_comb begin
        ena_s = (state_s == DRIVE);
    end
`endif

    // Scan state and registered drive outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= BLANK;
            dwell_r       <= {DW{1'b0}};
            x_r           <= {XW{1'b0}};
            ena_r         <= 1'b0;
            frame_start_r <= 1'b1;
        end else begin
            state_r       <= state_s;
            dwell_r       <= dwell_s;
            x_r           <= x_s;
            ena_r         <= ena_s;
            frame_start_r <= frame_start_s;
        end
    end

    // Double buffer: an accepted frame waits in pending until the next frame boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_r      <= {(N*N){1'b0}};
            pending_full_r <= 1'b0;
            cells_r        <= {(N*N){1'b0}};
        end else begin
            if (swap_s && pending_full_r) begin
                cells_r        <= pending_r;
                pending_full_r <= 1'b0;
            end else if (accept_s) begin
                pending_r      <= cells_in;
                pending_full_r <= 1'b1;
            end else begin
                pending_full_r <= pending_full_r;
            end
        end
    end

    assign cells_ready = ~pending_full_r;
    assign ena         = ena_r;
    assign x           = x_r;
    assign cells       = cells_r;
    assign frame_start = frame_start_r;

endmodule

// File: tb/tb_led_column_scanner.sv
// Directed self-checking bench for led_column_scanner: scan timing, handshake, swap edge, reset,
// and (when LED_SCAN_BRIGHTNESS_EN is defined) PWM brightness.
module tb_led_column_scanner;

    localparam int N  = 5;
    localparam int BT = 1;
`ifdef LED_SCAN_BRIGHTNESS_EN
    localparam int TPC = 16;
`else
    localparam int TPC = 4;
`endif
    localparam int P  = BT + TPC;
    localparam int FP = N * P;

    localparam logic [24:0] V1 = 25'h1555555;
    localparam logic [24:0] FA = 25'h0000001;
    localparam logic [24:0] FB = 25'h1FFFFFF;
    localparam logic [24:0] FC = 25'h0ABCDEF;
    localparam logic [24:0] FD = 25'h0F0F0F0;
    localparam logic [24:0] FE = 25'h1234567;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [24:0] cells_in = 25'h0;
    logic        cells_valid = 1'b0;
    logic        cells_ready;
    logic        ena;
    logic [3:0]  x;
    logic [24:0] cells;
    logic        frame_start;
`ifdef LED_SCAN_BRIGHTNESS_EN
    logic [3:0]  brightness = 4'd15;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int bright_eff = 16;

    always #5 clk = ~clk;

    led_column_scanner #(.N(N), .TICKS_PER_COL(TPC), .BLANK_TICKS(BT)) dut (
        .clk(clk),
        .rst(rst),
        .cells_in(cells_in),
        .cells_valid(cells_valid),
        .cells_ready(cells_ready),
`ifdef LED_SCAN_BRIGHTNESS_EN
        .brightness(brightness),
`endif
        .ena(ena),
        .x(x),
        .cells(cells),
        .frame_start(frame_start)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // One clock; cyc restarts at 0 on a reset edge. Scan outputs are checked every cycle.
    task automatic tick();
        logic was_rst;
        int   c;
        was_rst = rst;
        @(posedge clk);
        #1;
        if (was_rst) cyc = 0;
        else cyc++;
        c = cyc % P;
        check("x", {28'h0, x}, (cyc / P) % N);
        check("ena", {31'h0, ena}, {31'h0, (c >= BT) && ((c - BT) < bright_eff)});
        check("frame_start", {31'h0, frame_start}, {31'h0, (cyc % FP) == 0});
    endtask

    task automatic run_until(input int target);
        while (cyc < target) tick();
    endtask

    task automatic check_buf(input string tag, input logic [24:0] exp_cells, input logic exp_ready);
        check({tag, "_cells"}, {7'h0, cells}, {7'h0, exp_cells});
        check({tag, "_ready"}, {31'h0, cells_ready}, {31'h0, exp_ready});
    endtask

    initial begin
`ifdef LED_SCAN_BRIGHTNESS_EN
        bright_eff = 15;
`endif
        // Reset for two cycles, then check reset values.
        tick();
        tick();
        check_buf("reset", 25'h0, 1'b1);
        rst = 1'b0;

        // Single frame offered at cycle 3.
        run_until(3);
        cells_in    = V1;
        cells_valid = 1'b1;
        tick();
        cells_valid = 1'b0;
        check_buf("single_c4", 25'h0, 1'b0);
        run_until(FP - 1);
        check_buf("single_before_swap", 25'h0, 1'b0);
        tick();
        check_buf("single_swap", V1, 1'b1);

        // Back-pressure: A then B with valid held.
        cells_in    = FA;
        cells_valid = 1'b1;
        tick();
        cells_in = FB;
        check_buf("bp_a_accepted", V1, 1'b0);
        run_until(2 * FP - 1);
        check_buf("bp_b_stalled", V1, 1'b0);
        tick();
        check_buf("bp_a_shown", FA, 1'b1);
        tick();
        cells_valid = 1'b0;
        check_buf("bp_b_accepted", FA, 1'b0);
        run_until(3 * FP - 1);
        check_buf("bp_a_full_frame", FA, 1'b0);
        tick();
        check_buf("bp_b_shown", FB, 1'b1);

        // Accept on the swap edge with pending empty: no bypass.
        run_until(4 * FP - 1);
        check_buf("swapedge_pre", FB, 1'b1);
        cells_in    = FC;
        cells_valid = 1'b1;
        tick();
        cells_valid = 1'b0;
        check_buf("swapedge_held", FB, 1'b0);
        run_until(5 * FP);
        check_buf("swapedge_shown", FC, 1'b1);

        // Reset mid-frame with a frame pending, and an offer on the reset edge.
        cells_in    = FD;
        cells_valid = 1'b1;
        tick();
        cells_valid = 1'b0;
        run_until(5 * FP + 3 * P + BT + 1);
        check_buf("midrst_pre", FC, 1'b0);
        rst         = 1'b1;
        cells_in    = FE;
        cells_valid = 1'b1;
        tick();
        rst         = 1'b0;
        cells_valid = 1'b0;
        check_buf("midrst_post", 25'h0, 1'b1);
        run_until(FP);
        check_buf("midrst_discarded", 25'h0, 1'b1);

`ifdef LED_SCAN_BRIGHTNESS_EN
        // Brightness changes are made in BLANK so they are latched on the next DRIVE entry.
        brightness = 4'd4;
        bright_eff = 4;
        run_until(2 * FP);
        brightness = 4'd0;
        bright_eff = 0;
        run_until(3 * FP);
        check_buf("bright_buf", 25'h0, 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
